// File: rtl/swizzle_pkg.sv
// Shared definitions for the CRAM-to-DRAM read-back swizzle.
//   SWZ_DWIDTH    default tile edge / port width
//   SWZ_AWIDTH    default CRAM address width
//   rd_state_e    reader FSM states
//   tiles_per_ram number of (possibly partial) tiles read from one compute RAM
package swizzle_pkg;

    localparam int SWZ_DWIDTH = 40;
    localparam int SWZ_AWIDTH = 9;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_WAIT,
        RD_DONE
    } rd_state_e;

    function automatic int tiles_per_ram(input int num_words, input int dwidth);
        return (num_words + dwidth - 1) / dwidth;
    endfunction

endpackage

// File: rtl/swizzle_tile_buffer.sv
// One DWIDTH x DWIDTH tile buffer: rows are written one CRAM word at a time,
// columns are read out so that the transpose falls out of the read mux.
// Ports:
//   clk, resetn  clock, async active-low reset (only the full flag is reset)
//   clear        zero every row this cycle (a same-cycle row write wins)
//   wr_en/wr_row/wr_data  row write port
//   set_full / set_empty  full flag control (set_full has priority)
//   rd_col -> rd_data     bit rd_col of rows 0..DWIDTH-1
//   full                  buffer holds a complete tile awaiting drain
module swizzle_tile_buffer
    import swizzle_pkg::*;
#(
    parameter int DWIDTH = SWZ_DWIDTH,
    localparam int RW = $clog2(DWIDTH)
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_row,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              set_full,
    input  logic              set_empty,
    input  logic [RW-1:0]     rd_col,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full
);

    logic full_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DWIDTH; gi++) begin : g_row
            logic [DWIDTH-1:0] row_reg;

            // Contents are don't-care after reset, so the array has no reset.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_row == RW'(gi))) begin
                    row_reg <= wr_data;
                end else if (clear) begin
                    row_reg <= '0;
                end
            end

            // Output bit gi of a column is bit rd_col of row gi: the transpose.
            assign rd_data[gi] = row_reg[rd_col];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_reg <= 1'b0;
        end else if (set_full) begin
            full_reg <= 1'b1;
        end else if (set_empty) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;

endmodule

// File: rtl/swizzle_cram_to_dram.sv
// Read-back swizzle: reads compute-RAM words tile by tile into a ping/pong
// pair of tile buffers and streams each tile's columns (the transpose) to
// the memory controller with a valid/ready handshake.
// Ports:
//   clk, resetn               clock, async active-low reset
//   start / busy / done       job control (start ignored while busy)
//   ram_addr/ram_re/ram_num   CRAM read request, data returns 1 cycle later
//   ram_data_in               CRAM read data
//   mem_ctrl_data_out/valid/ready  transposed output stream
//   mem_ctrl_parity           XOR of mem_ctrl_data_out, only when
//                             SWIZZLE_C2D_PARITY_EN is defined
module swizzle_cram_to_dram
    import swizzle_pkg::*;
#(
    parameter int DWIDTH     = SWZ_DWIDTH,
    parameter int AWIDTH     = SWZ_AWIDTH,
    parameter int NUM_WORDS  = 512,
    parameter int START_ADDR = 0,
    parameter int START_NUM  = 0,
    parameter int NUM_RAMS   = 16
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_re,
    output logic [15:0]       ram_num,
    input  logic [DWIDTH-1:0] ram_data_in,
    output logic [DWIDTH-1:0] mem_ctrl_data_out,
    output logic              mem_ctrl_valid,
    input  logic              mem_ctrl_ready
`ifdef SWIZZLE_C2D_PARITY_EN
    ,
    output logic              mem_ctrl_parity
`endif
);

    localparam int RW = $clog2(DWIDTH);
    localparam logic [AWIDTH-1:0] FIRST_ADDR = AWIDTH'(START_ADDR);
    localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(START_ADDR + NUM_WORDS - 1);
    localparam logic [15:0]       FIRST_NUM  = 16'(START_NUM);
    localparam logic [15:0]       LAST_NUM   = 16'(START_NUM + NUM_RAMS - 1);
    localparam logic [RW-1:0]     LAST_ROW   = RW'(DWIDTH - 1);

    rd_state_e         state_reg, state_next;
    logic              fill_sel_reg, fill_sel_next;     // 0: ping fills, 1: pong fills
    logic              held_reg, held_next;             // fill buffer complete, waiting to swap
    logic              reads_done_reg, reads_done_next; // final CRAM read of the job issued
    logic [RW-1:0]     row_reg, row_next;
    logic [AWIDTH-1:0] addr_reg, addr_next;
    logic [15:0]       num_reg, num_next;
    logic              wr_pend_reg, wr_pend_next;       // read data lands this cycle
    logic [RW-1:0]     wr_row_reg, wr_row_next;
    logic              tile_last_reg, tile_last_next;   // landing row completes the tile
    logic              drain_sel_reg;
    logic [RW-1:0]     col_reg;

    logic              ping_full, pong_full;
    logic [DWIDTH-1:0] ping_rd, pong_rd;
    logic              issue, fill_clear, swap;
    logic              other_full, fill_full, other_free;
    logic              accept, drain_last;

    assign other_full = fill_sel_reg ? ping_full : pong_full;
    assign fill_full  = fill_sel_reg ? pong_full : ping_full;

    // Only the non-filling buffer can be draining, so finishing its last
    // column frees it in the same cycle and the swap need not stall.
    assign other_free = !other_full || drain_last;

    always_comb begin
        state_next      = state_reg;
        fill_sel_next   = fill_sel_reg;
        held_next       = held_reg;
        reads_done_next = reads_done_reg;
        row_next        = row_reg;
        addr_next       = addr_reg;
        num_next        = num_reg;
        wr_pend_next    = 1'b0;
        wr_row_next     = wr_row_reg;
        tile_last_next  = 1'b0;
        issue           = 1'b0;
        fill_clear      = 1'b0;
        swap            = 1'b0;
        done            = 1'b0;

        case (state_reg)
            RD_IDLE: begin
                if (start) begin
                    state_next      = RD_READ;
                    addr_next       = FIRST_ADDR;
                    num_next        = FIRST_NUM;
                    row_next        = '0;
                    held_next       = 1'b0;
                    reads_done_next = 1'b0;
                end
            end
            RD_READ: begin
                if (wr_pend_reg && tile_last_reg) begin
                    // Last row lands now: hand the tile over or wait for room.
                    if (other_free) begin
                        swap       = 1'b1;
                        state_next = reads_done_reg ? RD_WAIT : RD_READ;
                    end else begin
                        held_next  = 1'b1;
                        state_next = RD_WAIT;
                    end
                end else begin
                    issue          = 1'b1;
                    // Zero the whole tile on its first read so rows that a
                    // partial tile never reads come out as zero.
                    fill_clear     = (row_reg == '0);
                    wr_pend_next   = 1'b1;
                    wr_row_next    = row_reg;
                    tile_last_next = (row_reg == LAST_ROW) || (addr_reg == LAST_ADDR);
                    row_next       = tile_last_next ? '0 : row_reg + 1'b1;
                    if (addr_reg == LAST_ADDR) begin
                        addr_next = FIRST_ADDR;
                        num_next  = num_reg + 16'd1;
                        if (num_reg == LAST_NUM) begin
                            reads_done_next = 1'b1;
                        end
                    end else begin
                        addr_next = addr_reg + 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (held_reg) begin
                    if (other_free) begin
                        swap       = 1'b1;
                        held_next  = 1'b0;
                        state_next = reads_done_reg ? RD_WAIT : RD_READ;
                    end
                end else if (drain_last && !fill_full) begin
                    // All reads issued and the final tile's last column is leaving.
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                done       = 1'b1;
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase

        if (swap) begin
            fill_sel_next = !fill_sel_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= RD_IDLE;
            fill_sel_reg   <= 1'b0;
            held_reg       <= 1'b0;
            reads_done_reg <= 1'b0;
            row_reg        <= '0;
            addr_reg       <= FIRST_ADDR;
            num_reg        <= FIRST_NUM;
            wr_pend_reg    <= 1'b0;
            wr_row_reg     <= '0;
            tile_last_reg  <= 1'b0;
            drain_sel_reg  <= 1'b0;
            col_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            fill_sel_reg   <= fill_sel_next;
            held_reg       <= held_next;
            reads_done_reg <= reads_done_next;
            row_reg        <= row_next;
            addr_reg       <= addr_next;
            num_reg        <= num_next;
            wr_pend_reg    <= wr_pend_next;
            wr_row_reg     <= wr_row_next;
            tile_last_reg  <= tile_last_next;
            if (accept) begin
                col_reg       <= drain_last ? '0 : col_reg + 1'b1;
                drain_sel_reg <= drain_sel_reg ^ drain_last;
            end
        end
    end

    swizzle_tile_buffer #(.DWIDTH(DWIDTH)) u_ping (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (fill_clear && !fill_sel_reg),
        .wr_en     (wr_pend_reg && !fill_sel_reg),
        .wr_row    (wr_row_reg),
        .wr_data   (ram_data_in),
        .set_full  (swap && !fill_sel_reg),
        .set_empty (drain_last && !drain_sel_reg),
        .rd_col    (col_reg),
        .rd_data   (ping_rd),
        .full      (ping_full)
    );

    swizzle_tile_buffer #(.DWIDTH(DWIDTH)) u_pong (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (fill_clear && fill_sel_reg),
        .wr_en     (wr_pend_reg && fill_sel_reg),
        .wr_row    (wr_row_reg),
        .wr_data   (ram_data_in),
        .set_full  (swap && fill_sel_reg),
        .set_empty (drain_last && drain_sel_reg),
        .rd_col    (col_reg),
        .rd_data   (pong_rd),
        .full      (pong_full)
    );

    // Valid comes straight from the reset-cleared full flags, so it drops
    // the moment resetn falls.
    assign mem_ctrl_valid    = drain_sel_reg ? pong_full : ping_full;
    assign mem_ctrl_data_out = mem_ctrl_valid ? (drain_sel_reg ? pong_rd : ping_rd) : '0;
    assign accept            = mem_ctrl_valid && mem_ctrl_ready;
    assign drain_last        = accept && (col_reg == LAST_ROW);

`ifdef SWIZZLE_C2D_PARITY_EN
    assign mem_ctrl_parity = ^mem_ctrl_data_out;
`endif

    assign busy     = (state_reg != RD_IDLE);
    assign ram_re   = issue;
    assign ram_addr = addr_reg;
    assign ram_num  = num_reg;

endmodule
